alu_word_sequencer: RTL and testbench
=====================================

Name: alu_word_sequencer

Overview:
- Upstream controller for the 4-bit combinational ALU slice; executes one W-bit operation as NIBBLES serial nibble passes, LSB nibble first.
- Latches operands and command on a valid/ready handshake and drives the ALU's d1/d2/ctrl inputs.
- Chains carry_out into the next nibble's carry_in and assembles the word result, carry and zero flags for downstream consumers.

Parameters:
- NIBBLES, 4, number of 4-bit passes; word width W = 4*NIBBLES; legal range 2..8.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- op_a  in  W  first operand (ALU d1 side).
- op_b  in  W  second operand (ALU d2 side).
- cmd  in  5  AluCmd encoding.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  W  word result.
- carry_out  out  1  carry of the final nibble pass.
- zero  out  1  result == 0.
- alu_d1  out  4  nibble to ALU d1.
- alu_d2  out  4  nibble to ALU d2.
- alu_ctrl  out  5  control word to ALU.
- alu_res  in  4  ALU result nibble.
- alu_carry_out  in  1  ALU carry out.

Behaviour:
- One clock domain; rst_n is asynchronous, active-low.
- Reset values: state IDLE, in_ready 1, out_valid 0, result 0, carry_out 0, zero 0, alu_d1/alu_d2/alu_ctrl 0, nibble index 0, carry register 0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch op_a, op_b and cmd, clear idx and go to RUN. Input changes after the accept edge are ignored.
  - RUN: in_ready=0. Combinationally drive alu_d1=a[idx], alu_d2=b[idx] and alu_ctrl[3:0]=cmd_q[3:0]. Each edge: write alu_res into result nibble idx and alu_carry_out into the carry register, then increment idx. On idx==NIBBLES-1, go to DONE.
  - DONE: out_valid=1; result, carry_out and zero held stable. On out_ready, go to IDLE. No accept occurs in DONE.
- alu_ctrl[4] (carry_in) selection is decoded from bit fields, not the enum:
  - carry_disable (bit2)==0 (ADD/SUB/COMP): idx 0 uses cmd_q[4]; idx>0 uses the carry register.
  - cmd_q[2:0]==3'b111 (RSHFT): bit op_b[4*(idx+1)] for idx<NIBBLES-1; 0 for the top nibble (logical shift).
  - Otherwise (logic ops): cmd_q[4].
- Latency: out_valid rises NIBBLES edges after the accept edge. Minimum spacing between accepts is NIBBLES+2 cycles.
- carry_out = carry register after the last pass.
  - SUB: carry_out 1 means no borrow.
  - COMP: A-B-1 chained over the whole word; carry_out 1 means A>B when A!=B.
  - Logic ops/RSHFT: carry_out is 0, because the ALU disables carry.
- zero is computed from the final assembled result for all commands.
- out_ready held high in RUN has no effect. out_ready held low in DONE holds indefinitely.
- Undefined cmd codes are forwarded unchanged, using the bit-field rules above.
- rst_n asserted in any state aborts the operation at once and restores all reset values.

Optional Feature:
- Macro: ALU_SEQ_OVERFLOW_EN.
- Defined: adds output port overflow (1 bit, reset 0), valid with out_valid. Let sa, sb, sr be the MSBs of a, b and result.
  - ADD: overflow = (sa==sb)&&(sr!=sa).
  - SUB: overflow = (sa!=sb)&&(sr!=sa).
  - All other commands: 0.
- Undefined: port absent, no extra logic.

Decomposition:
- Package alu_pkg holds AluCmd, AluCtrlInternal and AluCtrl, plus NIBBLE_W=4 and the sequencer state enum (IDLE, RUN, DONE). The ALU and this block share the package.
- One sub-module, alu_seq_carry_sel: the combinational alu_ctrl[4] selector (inputs cmd_q, idx, carry register, op_b).
- FSM and datapath stay in alu_word_sequencer.

Test Plan:
- ADD, 0x00FF + 0x0001 -> result 0x0100, carry_out 0, zero 0; out_valid 4 edges after accept. 0xFFFF + 0x0001 -> 0x0000, carry_out 1, zero 1.
- SUB, 0x1000 - 0x0001 -> 0x0FFF, carry_out 1. 0x0001 - 0x0002 -> 0xFFFF, carry_out 0.
- COMP, A=0x1234 B=0x1233 -> carry_out 1. A=0x1233 B=0x1234 -> carry_out 0. AND 0xF0F0&0x3C3C -> 0x3030, carry_out 0.
- RSHFT, op_b=0x8421 -> 0x4210. op_b=0x0010 -> 0x0008 (cross-nibble bit). op_a=0xFFFF is ignored.
- Backpressure, out_ready low 3 cycles in DONE -> out_valid/result stable, in_ready 0, in_valid pulses ignored; one cycle after out_ready, in_ready 1.
- Reset mid-RUN at idx 2 -> out_valid 0, in_ready 1 immediately; next ADD 0x0003+0x0004 -> 0x0007. With ALU_SEQ_OVERFLOW_EN, ADD 0x7FFF+0x0001 -> overflow 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU command/control encodings and the word sequencer state type.
// Used by both the 4-bit ALU slice and alu_word_sequencer.
package alu_pkg;

  localparam int NIBBLE_W = 4;

  // Bit 2 disables the carry chain; bit 0 inverts d2 for subtract-style ops.
  typedef enum logic [3:0] {
    CTRL_ADD   = 4'b0000,
    CTRL_SUB   = 4'b0001,
    CTRL_AND   = 4'b0100,
    CTRL_OR    = 4'b0101,
    CTRL_XOR   = 4'b0110,
    CTRL_RSHFT = 4'b0111
  } AluCtrlInternal;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'b00000,
    ALU_SUB   = 5'b10001,
    ALU_COMP  = 5'b00001,
    ALU_AND   = 5'b00100,
    ALU_OR    = 5'b00101,
    ALU_XOR   = 5'b00110,
    ALU_RSHFT = 5'b00111
  } AluCmd;

  typedef struct packed {
    logic           carry_in;
    AluCtrlInternal op;
  } AluCtrl;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_word_sequencer_carry_sel.sv
// Carry-in selector for each nibble pass: chained carry for arithmetic,
// next-nibble LSB for right shift, command carry bit for logic ops.
module alu_seq_carry_sel
  import alu_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        carry_in_cmd_i,
  input  logic [2:0]                  op_low_i,
  input  logic [$clog2(NIBBLES)-1:0]  idx_i,
  input  logic                        carry_i,
  input  logic [NIBBLES-2:0]          shift_bits_i,
  output logic                        carry_in_o
);
  localparam int IDX_W = $clog2(NIBBLES);

  logic shift_s;

  // Top nibble never matches the loop, so a logical shift fills with 0.
  always_comb begin
    shift_s = 1'b0;
    for (int n = 0; n < NIBBLES - 1; n++) begin
      shift_s = shift_s | (shift_bits_i[n] & (idx_i == IDX_W'(n)));
    end
    if (op_low_i[2] == 1'b0) begin
      carry_in_o = (idx_i == '0) ? carry_in_cmd_i : carry_i;
    end else if (op_low_i == 3'b111) begin
      carry_in_o = shift_s;
    end else begin
      carry_in_o = carry_in_cmd_i;
    end
  end

endmodule

// File: rtl/alu_word_sequencer.sv
// Runs one W-bit operation as NIBBLES LSB-first passes through a 4-bit ALU slice.
// Define ALU_SEQ_OVERFLOW_EN to add a signed overflow output for ADD/SUB.
module alu_word_sequencer
  import alu_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]   op_a,
  input  logic [NIBBLE_W*NIBBLES-1:0]   op_b,
  input  logic [4:0]                    cmd,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]   result,
  output logic                          carry_out,
  output logic                          zero,
`ifdef ALU_SEQ_OVERFLOW_EN
  output logic                          overflow,
`endif
  output logic [3:0]                    alu_d1,
  output logic [3:0]                    alu_d2,
  output logic [4:0]                    alu_ctrl,
  input  logic [3:0]                    alu_res,
  input  logic                          alu_carry_out
);
  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);

  seq_state_e            state_q;
  logic [W-1:0]          a_q, b_q, result_q, result_d;
  logic [4:0]            cmd_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  carry_q, in_ready_q, out_valid_q, zero_q;
  logic [NIBBLE_W-1:0]   nib_a_s, nib_b_s;
  logic [NIBBLES-2:0]    shift_bits_s;
  logic                  carry_in_s, last_s, run_s;
  AluCtrl                ctrl_s;

  // Nibble mux for the ALU operands and merge of the returning result nibble.
  always_comb begin
    nib_a_s  = '0;
    nib_b_s  = '0;
    result_d = result_q;
    for (int n = 0; n < NIBBLES; n++) begin
      nib_a_s = nib_a_s | (a_q[n*NIBBLE_W +: NIBBLE_W] & {NIBBLE_W{idx_q == IDX_W'(n)}});
      nib_b_s = nib_b_s | (b_q[n*NIBBLE_W +: NIBBLE_W] & {NIBBLE_W{idx_q == IDX_W'(n)}});
      result_d[n*NIBBLE_W +: NIBBLE_W] = (idx_q == IDX_W'(n)) ? alu_res
                                                              : result_q[n*NIBBLE_W +: NIBBLE_W];
    end
  end

  for (genvar g = 0; g < NIBBLES - 1; g++) begin : g_shift
    assign shift_bits_s[g] = b_q[(g+1)*NIBBLE_W];
  end

  alu_seq_carry_sel #(.NIBBLES(NIBBLES)) u_carry_sel (
    .carry_in_cmd_i (cmd_q[4]),
    .op_low_i       (cmd_q[2:0]),
    .idx_i          (idx_q),
    .carry_i        (carry_q),
    .shift_bits_i   (shift_bits_s),
    .carry_in_o     (carry_in_s)
  );

  assign run_s    = (state_q == S_RUN);
  assign last_s   = (idx_q == IDX_W'(NIBBLES - 1));
  assign ctrl_s   = '{carry_in: carry_in_s, op: AluCtrlInternal'(cmd_q[3:0])};
  assign alu_d1   = run_s ? nib_a_s : 4'd0;
  assign alu_d2   = run_s ? nib_b_s : 4'd0;
  assign alu_ctrl = run_s ? ctrl_s  : 5'd0;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry_out = carry_q;
  assign zero      = zero_q;

`ifdef ALU_SEQ_OVERFLOW_EN
  logic ovf_q, ovf_d;
  assign ovf_d = ((cmd_q == ALU_ADD) && (a_q[W-1] == b_q[W-1]) && (result_d[W-1] != a_q[W-1]))
              || ((cmd_q == ALU_SUB) && (a_q[W-1] != b_q[W-1]) && (result_d[W-1] != a_q[W-1]));
  assign overflow = ovf_q;

  // Overflow flag captured on the final pass alongside zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (run_s && last_s) begin
      ovf_q <= ovf_d;
    end
  end
`endif

  // Sequencer FSM: accept, one nibble per cycle, then hold the result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      cmd_q       <= 5'd0;
      idx_q       <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q        <= op_a;
            b_q        <= op_b;
            cmd_q      <= cmd;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          result_q <= result_d;
          carry_q  <= alu_carry_out;
          if (last_s) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            zero_q      <= (result_d == '0);
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Scoreboard bench for alu_word_sequencer with a behavioural 4-bit ALU slice and a
// word-level reference model; define ALU_SEQ_OVERFLOW_EN to also check overflow.
module tb_alu_word_sequencer;
  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  typedef struct packed {
    logic [W-1:0] res;
    logic         carry;
    logic         zero;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic [4:0]   cmd = 5'd0;
  logic         in_ready, out_valid, carry_out, zero;
  logic [W-1:0] result;
  logic [3:0]   alu_d1, alu_d2, alu_res;
  logic [4:0]   alu_ctrl, alu_sum;
  logic         alu_carry_out;
`ifdef ALU_SEQ_OVERFLOW_EN
  logic         overflow;
`endif

  int   n_vec = 0;
  int   n_mis = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  alu_word_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cmd(cmd),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .zero(zero),
`ifdef ALU_SEQ_OVERFLOW_EN
    .overflow(overflow),
`endif
    .alu_d1(alu_d1), .alu_d2(alu_d2), .alu_ctrl(alu_ctrl),
    .alu_res(alu_res), .alu_carry_out(alu_carry_out)
  );

  always #5 clk = ~clk;

  // Behavioural 4-bit ALU slice driven by the sequencer.
  always_comb begin
    alu_sum       = 5'd0;
    alu_res       = 4'd0;
    alu_carry_out = 1'b0;
    if (alu_ctrl[2] == 1'b0) begin
      alu_sum = {1'b0, alu_d1} + {1'b0, (alu_ctrl[0] ? ~alu_d2 : alu_d2)} + {4'd0, alu_ctrl[4]};
      alu_res       = alu_sum[3:0];
      alu_carry_out = alu_sum[4];
    end else begin
      case (alu_ctrl[1:0])
        2'b00:   alu_res = alu_d1 & alu_d2;
        2'b01:   alu_res = alu_d1 | alu_d2;
        2'b10:   alu_res = alu_d1 ^ alu_d2;
        default: alu_res = {alu_ctrl[4], alu_d2[3:1]};
      endcase
    end
  end

  // Word-level reference: what the whole operation should produce.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] c);
    exp_t         e;
    logic [W:0]   s;
    logic [W-1:0] bb;
    e = '0;
    if (c[2] == 1'b0) begin
      bb = c[0] ? ~b : b;
      s = {1'b0, a} + {1'b0, bb} + (W+1)'(c[4]);
      e.res   = s[W-1:0];
      e.carry = s[W];
    end else begin
      case (c[1:0])
        2'b00:   e.res = a & b;
        2'b01:   e.res = a | b;
        2'b10:   e.res = a ^ b;
        default: e.res = b >> 1;
      endcase
    end
    e.zero = (e.res == '0);
    if (c == 5'b00000)      e.ovf = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
    else if (c == 5'b10001) e.ovf = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Issue one request, check latency/backpressure behaviour, hand the expectation to the monitor.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] c,
                       input exp_t e, input int hold);
    int t;
    int k;
    t = 0;
    while (!in_ready && t < 40) begin @(posedge clk); #1; t++; end
    chk("in_ready_before_issue", in_ready, 1);
    if (!in_ready) return;
    op_a = a; op_b = b; cmd = c; in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    in_valid = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom); cmd = 5'($urandom);
    k = 0;
    while (k < 40) begin
      @(posedge clk); #1; k++;
      if (out_valid) break;
      out_ready = 1'($urandom_range(0, 1));
    end
    chk("latency", k, NIBBLES);
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_result", result, e.res);
      chk("bp_in_ready", in_ready, 0);
      in_valid = (h % 2 == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_hs_in_ready", in_ready, 1);
    chk("post_hs_out_valid", out_valid, 0);
  endtask

  task automatic dir(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] c,
                     input logic [W-1:0] r, input logic cy, input logic z, input logic ov, input int hold);
    exp_t e;
    e = '{res: r, carry: cy, zero: z, ovf: ov};
    issue(a, b, c, e, hold);
  endtask

  // Monitor: compare every delivered result against the oldest expectation.
  always begin
    @(negedge clk); #2;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_mis++;
        $display("FAIL scoreboard: result 0x%0h delivered with no expectation queued", result);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result", result, mon_e.res);
        chk("carry_out", carry_out, mon_e.carry);
        chk("zero", zero, mon_e.zero);
`ifdef ALU_SEQ_OVERFLOW_EN
        chk("overflow", overflow, mon_e.ovf);
`endif
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic [4:0]   rc;
    int           t;
    #2 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_carry", carry_out, 0);
    chk("rst_zero", zero, 0);
    chk("rst_alu_d1", alu_d1, 0);
    chk("rst_alu_d2", alu_d2, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    dir(16'h00FF, 16'h0001, 5'b00000, 16'h0100, 1'b0, 1'b0, 1'b0, 0);
    dir(16'hFFFF, 16'h0001, 5'b00000, 16'h0000, 1'b1, 1'b1, 1'b0, 1);
    dir(16'h1000, 16'h0001, 5'b10001, 16'h0FFF, 1'b1, 1'b0, 1'b0, 0);
    dir(16'h0001, 16'h0002, 5'b10001, 16'hFFFF, 1'b0, 1'b0, 1'b0, 2);
    dir(16'h1234, 16'h1233, 5'b00001, 16'h0000, 1'b1, 1'b1, 1'b0, 0);
    dir(16'h1233, 16'h1234, 5'b00001, 16'hFFFE, 1'b0, 1'b0, 1'b0, 0);
    dir(16'hF0F0, 16'h3C3C, 5'b00100, 16'h3030, 1'b0, 1'b0, 1'b0, 3);
    dir(16'hFFFF, 16'h8421, 5'b00111, 16'h4210, 1'b0, 1'b0, 1'b0, 0);
    dir(16'hFFFF, 16'h0010, 5'b00111, 16'h0008, 1'b0, 1'b0, 1'b0, 1);
    dir(16'h7FFF, 16'h0001, 5'b00000, 16'h8000, 1'b0, 1'b0, 1'b1, 0);

    // Abort an operation two passes in, then confirm a clean restart.
    op_a = 16'h1111; op_b = 16'h2222; cmd = 5'b00000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_result", result, 0);
    chk("abort_alu_ctrl", alu_ctrl, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    dir(16'h0003, 16'h0004, 5'b00000, 16'h0007, 1'b0, 1'b0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 5'($urandom);
      if (i % 8 == 0) rb = ra;
      issue(ra, rb, rc, model(ra, rb, rc), int'($urandom_range(0, 3)));
    end

    t = 0;
    while (exp_q.size() != 0 && t < 20) begin @(posedge clk); t++; end
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
